// File: rtl/stc_pkg.sv
// Shared types and size helpers for the unstructured-sparse PE controller.
package stc_pkg;

    localparam int DEF_N       = 8;
    localparam int DEF_DW_DATA = 8;
    localparam int DEF_K       = 16;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        ZERO,
        DRAIN,
        WAIT_OUT
    } state_t;

    function automatic int addr_w(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    function automatic int nnz_w(input int k);
        return $clog2(k) + 1;
    endfunction

endpackage

// File: rtl/stc_issue_stage.sv
// One-deep issue -> PE pipeline: launches the B-row read, range-checks the column,
// and presents value, B row and the load/acc enable one cycle later.
module stc_issue_stage
    import stc_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int DW_DATA = DEF_DW_DATA,
    parameter int K       = DEF_K,
    parameter int AW      = addr_w(K)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue,
    input  logic                 zero_op,
    input  logic                 first,
    input  logic [DW_DATA-1:0]   val,
    input  logic [AW:0]          col,
    input  logic [N*DW_DATA-1:0] b_rd_data,
    output logic                 b_rd_en,
    output logic [AW-1:0]        b_rd_addr,
    output logic                 col_oor,
    output logic [DW_DATA-1:0]   pe_A_element,
    output logic [N*DW_DATA-1:0] pe_B_row,
    output logic                 pe_load_en,
    output logic                 pe_acc_en
);

    logic               in_range;
    logic               vld_q;
    logic               first_q;
    logic               bzero_q;
    logic [DW_DATA-1:0] val_q;

    assign in_range  = col < (AW+1)'(K);
    assign b_rd_en   = issue && !zero_op && in_range;
    assign b_rd_addr = b_rd_en ? col[AW-1:0] : '0;
    assign col_oor   = issue && !zero_op && !in_range;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            bzero_q <= 1'b0;
            val_q   <= '0;
        end else begin
            vld_q <= issue;
            if (issue) begin
                val_q   <= zero_op ? '0 : val;
                first_q <= first;
                bzero_q <= zero_op || !in_range;
            end
        end
    end

    // b_rd_data is only meaningful the cycle after an in-range read, hence the gating.
    assign pe_A_element = vld_q ? val_q : '0;
    assign pe_B_row     = (vld_q && !bzero_q) ? b_rd_data : '0;
    assign pe_load_en   = vld_q && first_q;
    assign pe_acc_en    = vld_q && !first_q;

endmodule

// File: rtl/stc_pe_ctrl.sv
// Row sequencer for one sparse PE: accepts a row descriptor and its nonzeros,
// steers B rows into the PE, and presents the finished D row until accepted.
module stc_pe_ctrl
    import stc_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int DW_DATA = DEF_DW_DATA,
    parameter int K       = DEF_K,
    parameter int AW      = addr_w(K),
    parameter int NNZ_W   = nnz_w(K)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 row_valid,
    output logic                 row_ready,
    input  logic [NNZ_W-1:0]     row_nnz,
    input  logic                 elem_valid,
    output logic                 elem_ready,
    input  logic [DW_DATA-1:0]   elem_val,
    input  logic [AW:0]          elem_col,
    output logic                 b_rd_en,
    output logic [AW-1:0]        b_rd_addr,
    input  logic [N*DW_DATA-1:0] b_rd_data,
    output logic [DW_DATA-1:0]   pe_A_element,
    output logic [N*DW_DATA-1:0] pe_B_row,
    output logic                 pe_load_en,
    output logic                 pe_acc_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 col_err
);

    state_t           state;
    state_t           state_nxt;
    logic [NNZ_W-1:0] remaining;
    logic             first;
    logic             row_hs;
    logic             elem_hs;
    logic             issue;
    logic             col_oor;

    assign row_hs  = row_valid && (state == IDLE);
    assign elem_hs = elem_valid && (state == RUN) && (remaining != '0);
    assign issue   = elem_hs || (state == ZERO);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        row_ready  = 1'b0;
        elem_ready = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                row_ready = !reset;
                if (row_valid) state_nxt = (row_nnz == '0) ? ZERO : RUN;
            end
            RUN: begin
                elem_ready = (remaining != '0);
                if (elem_valid && remaining == NNZ_W'(1)) state_nxt = DRAIN;
            end
            ZERO:  state_nxt = DRAIN;
            DRAIN: state_nxt = WAIT_OUT;
            WAIT_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            first     <= 1'b0;
            col_err   <= 1'b0;
        end else if (row_hs) begin
            remaining <= row_nnz;
            first     <= 1'b1;
            col_err   <= 1'b0;
        end else if (elem_hs) begin
            remaining <= remaining - NNZ_W'(1);
            first     <= 1'b0;
            if (col_oor) col_err <= 1'b1;
        end
    end

    // An empty row borrows the issue slot to load C_row through a zero product.
    stc_issue_stage #(
        .N       (N),
        .DW_DATA (DW_DATA),
        .K       (K),
        .AW      (AW)
    ) u_issue (
        .clk          (clk),
        .reset        (reset),
        .issue        (issue),
        .zero_op      (state == ZERO),
        .first        (first || (state == ZERO)),
        .val          (elem_val),
        .col          (elem_col),
        .b_rd_data    (b_rd_data),
        .b_rd_en      (b_rd_en),
        .b_rd_addr    (b_rd_addr),
        .col_oor      (col_oor),
        .pe_A_element (pe_A_element),
        .pe_B_row     (pe_B_row),
        .pe_load_en   (pe_load_en),
        .pe_acc_en    (pe_acc_en)
    );

endmodule

// File: tb/tb_stc_pe_ctrl.sv
// Directed bench for stc_pe_ctrl with a B-buffer model and a behavioural PE.
module tb_stc_pe_ctrl;

    localparam int N     = 8;
    localparam int DW    = 8;
    localparam int K     = 16;
    localparam int AW    = 4;
    localparam int NNZ_W = 5;

    localparam logic [63:0] B2     = 64'h0001020304050607;
    localparam logic [63:0] B5     = 64'h0008020704050300;
    localparam logic [63:0] ONES   = 64'h0101010101010101;
    localparam logic [63:0] D_C1   = 64'h001106110C0F0C07;
    localparam logic [63:0] D_2B5  = 64'h0010040E080A0600;
    localparam logic [63:0] D_C6   = 64'h011907160D100A01;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              row_valid = 1'b0;
    logic              row_ready;
    logic [NNZ_W-1:0]  row_nnz = '0;
    logic              elem_valid = 1'b0;
    logic              elem_ready;
    logic [DW-1:0]     elem_val = '0;
    logic [AW:0]       elem_col = '0;
    logic              b_rd_en;
    logic [AW-1:0]     b_rd_addr;
    logic [N*DW-1:0]   b_rd_data = '0;
    logic [DW-1:0]     pe_A_element;
    logic [N*DW-1:0]   pe_B_row;
    logic              pe_load_en;
    logic              pe_acc_en;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              col_err;

    logic [N*DW-1:0]   bmem [K];
    logic [N*DW-1:0]   c_row = '0;
    logic [N*DW-1:0]   d_row = '0;

    int n_checks = 0;
    int n_errors = 0;
    int n_load = 0, n_acc = 0, n_rd = 0, n_overlap = 0;
    int l0, a0, r0;

    always #5 clk = ~clk;

    stc_pe_ctrl #(.N(N), .DW_DATA(DW), .K(K), .AW(AW), .NNZ_W(NNZ_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .row_valid    (row_valid),
        .row_ready    (row_ready),
        .row_nnz      (row_nnz),
        .elem_valid   (elem_valid),
        .elem_ready   (elem_ready),
        .elem_val     (elem_val),
        .elem_col     (elem_col),
        .b_rd_en      (b_rd_en),
        .b_rd_addr    (b_rd_addr),
        .b_rd_data    (b_rd_data),
        .pe_A_element (pe_A_element),
        .pe_B_row     (pe_B_row),
        .pe_load_en   (pe_load_en),
        .pe_acc_en    (pe_acc_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .col_err      (col_err)
    );

    function automatic logic [N*DW-1:0] mac(input logic [N*DW-1:0] base,
                                            input logic [DW-1:0] a,
                                            input logic [N*DW-1:0] b);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i*DW +: DW] = base[i*DW +: DW] + a * b[i*DW +: DW];
        end
        return r;
    endfunction

    // B buffer: data valid one cycle after the read strobe
    always @(posedge clk) begin
        if (b_rd_en) b_rd_data <= bmem[b_rd_addr];
    end

    // Behavioural PE, modulo 2^DW per lane
    always @(posedge clk) begin
        if (pe_load_en)     d_row <= mac(c_row, pe_A_element, pe_B_row);
        else if (pe_acc_en) d_row <= mac(d_row, pe_A_element, pe_B_row);
    end

    always @(negedge clk) begin
        if (pe_load_en) n_load <= n_load + 1;
        if (pe_acc_en)  n_acc  <= n_acc + 1;
        if (b_rd_en)    n_rd   <= n_rd + 1;
        if (pe_load_en && pe_acc_en) n_overlap <= n_overlap + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < K; i++) bmem[i] = {N{8'(i + 8'h30)}};
        bmem[2] = B2;
        bmem[5] = B5;

        // Reset state
        step();
        check("rst_row_ready", 64'(row_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_enables", 64'({pe_load_en, pe_acc_en, b_rd_en}), 64'd0);
        check("rst_col_err", 64'(col_err), 64'd0);
        reset = 1'b0;
        #1;
        check("rst_row_ready_after", 64'(row_ready), 64'd1);
        check("rst_elem_ready", 64'(elem_ready), 64'd0);

        // Case 1: back-to-back nonzeros (1,col2),(2,col5), C=0
        c_row = '0;
        row_valid = 1'b1; row_nnz = 5'd2;
        step();
        row_valid = 1'b0;
        check("c1_row_ready_low", 64'(row_ready), 64'd0);
        elem_valid = 1'b1; elem_val = 8'd1; elem_col = 5'd2;
        #1;
        check("c1_rd_en0", 64'(b_rd_en), 64'd1);
        check("c1_rd_addr0", 64'(b_rd_addr), 64'd2);
        step();
        elem_val = 8'd2; elem_col = 5'd5;
        #1;
        check("c1_load", 64'({pe_load_en, pe_acc_en}), 64'b10);
        check("c1_A0", 64'(pe_A_element), 64'd1);
        check("c1_B0", pe_B_row, B2);
        check("c1_rd_addr1", 64'(b_rd_addr), 64'd5);
        step();
        elem_valid = 1'b0;
        check("c1_acc", 64'({pe_load_en, pe_acc_en}), 64'b01);
        check("c1_elem_ready_drain", 64'(elem_ready), 64'd0);
        check("c1_out_valid_early", 64'(out_valid), 64'd0);
        step();
        check("c1_out_valid", 64'(out_valid), 64'd1);
        check("c1_D", d_row, D_C1);
        check("c1_wait_enables", 64'({pe_load_en, pe_acc_en}), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("c1_out_done", 64'(out_valid), 64'd0);
        check("c1_idle_ready", 64'(row_ready), 64'd1);

        // Case 2: empty row loads C_row; ZERO takes the issue slot, out_valid 2 cycles later
        c_row = ONES;
        r0 = n_rd; l0 = n_load;
        row_valid = 1'b1; row_nnz = 5'd0;
        step();
        row_valid = 1'b0;
        check("c2_zero_no_rd", 64'(b_rd_en), 64'd0);
        check("c2_zero_no_load_yet", 64'(pe_load_en), 64'd0);
        check("c2_zero_elem_ready", 64'(elem_ready), 64'd0);
        step();
        check("c2_load", 64'({pe_load_en, pe_acc_en}), 64'b10);
        check("c2_A_zero", 64'(pe_A_element), 64'd0);
        check("c2_B_zero", pe_B_row, 64'd0);
        check("c2_out_valid_early", 64'(out_valid), 64'd0);
        step();
        check("c2_out_valid", 64'(out_valid), 64'd1);
        check("c2_D", d_row, ONES);
        check("c2_rd_count", 64'(n_rd - r0), 64'd0);
        check("c2_load_count", 64'(n_load - l0), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Case 3: same row as case 1 with a 3-cycle gap between nonzeros
        c_row = '0;
        row_valid = 1'b1; row_nnz = 5'd2;
        step();
        row_valid = 1'b0;
        elem_valid = 1'b1; elem_val = 8'd1; elem_col = 5'd2;
        l0 = n_load; a0 = n_acc;
        step();
        elem_valid = 1'b0;
        check("c3_load", 64'({pe_load_en, pe_acc_en}), 64'b10);
        for (int i = 0; i < 3; i++) begin
            step();
            check("c3_gap_enables", 64'({pe_load_en, pe_acc_en}), 64'd0);
        end
        elem_valid = 1'b1; elem_val = 8'd2; elem_col = 5'd5;
        #1;
        check("c3_elem_ready", 64'(elem_ready), 64'd1);
        step();
        elem_valid = 1'b0;
        check("c3_acc", 64'({pe_load_en, pe_acc_en}), 64'b01);
        check("c3_out_valid_early", 64'(out_valid), 64'd0);
        step();
        check("c3_out_valid", 64'(out_valid), 64'd1);
        check("c3_D", d_row, D_C1);
        check("c3_enable_count", 64'((n_load - l0) + (n_acc - a0)), 64'd2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Case 4: out-of-range column (3,col16) then (1,col2)
        c_row = '0;
        row_valid = 1'b1; row_nnz = 5'd2;
        step();
        row_valid = 1'b0;
        elem_valid = 1'b1; elem_val = 8'd3; elem_col = 5'd16;
        #1;
        check("c4_oor_no_rd", 64'(b_rd_en), 64'd0);
        check("c4_col_err_before", 64'(col_err), 64'd0);
        step();
        elem_val = 8'd1; elem_col = 5'd2;
        #1;
        check("c4_load", 64'({pe_load_en, pe_acc_en}), 64'b10);
        check("c4_B_zero", pe_B_row, 64'd0);
        check("c4_col_err_set", 64'(col_err), 64'd1);
        check("c4_rd_en_next", 64'(b_rd_en), 64'd1);
        step();
        elem_valid = 1'b0;
        check("c4_acc", 64'({pe_load_en, pe_acc_en}), 64'b01);
        step();
        check("c4_out_valid", 64'(out_valid), 64'd1);
        check("c4_D", d_row, B2);
        check("c4_col_err_held", 64'(col_err), 64'd1);

        // Case 5: consumer stalls 5 cycles while the next row waits
        row_valid = 1'b1; row_nnz = 5'd1;
        l0 = n_load; a0 = n_acc;
        for (int i = 0; i < 5; i++) begin
            step();
            check("c5_out_valid_hold", 64'(out_valid), 64'd1);
            check("c5_row_ready_low", 64'(row_ready), 64'd0);
        end
        check("c5_stall_enables", 64'((n_load - l0) + (n_acc - a0)), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("c5_out_done", 64'(out_valid), 64'd0);
        check("c5_row_ready", 64'(row_ready), 64'd1);
        check("c5_col_err_until_accept", 64'(col_err), 64'd1);
        step();
        row_valid = 1'b0;
        check("c5_accepted", 64'(row_ready), 64'd0);
        check("c5_col_err_cleared", 64'(col_err), 64'd0);
        check("c5_elem_ready", 64'(elem_ready), 64'd1);
        elem_valid = 1'b1; elem_val = 8'd2; elem_col = 5'd5;
        step();
        elem_valid = 1'b0;
        step();
        step();
        check("c5_out_valid", 64'(out_valid), 64'd1);
        check("c5_D", d_row, D_2B5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Case 6: reset in the PE stage of a 4-nnz row
        c_row = ONES;
        row_valid = 1'b1; row_nnz = 5'd4;
        step();
        row_valid = 1'b0;
        elem_valid = 1'b1; elem_val = 8'd1; elem_col = 5'd2;
        step();
        check("c6_load_before_rst", 64'(pe_load_en), 64'd1);
        reset = 1'b1;
        #1;
        check("c6_rst_enables", 64'({pe_load_en, pe_acc_en, b_rd_en}), 64'd0);
        check("c6_rst_out_valid", 64'(out_valid), 64'd0);
        check("c6_rst_elem_ready", 64'(elem_ready), 64'd0);
        elem_valid = 1'b0;
        step();
        reset = 1'b0;
        #1;
        check("c6_row_ready_after", 64'(row_ready), 64'd1);
        row_valid = 1'b1; row_nnz = 5'd1;
        step();
        row_valid = 1'b0;
        elem_valid = 1'b1; elem_val = 8'd3; elem_col = 5'd5;
        step();
        elem_valid = 1'b0;
        check("c6_load", 64'({pe_load_en, pe_acc_en}), 64'b10);
        step();
        check("c6_out_valid", 64'(out_valid), 64'd1);
        check("c6_D", d_row, D_C6);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        check("never_load_and_acc", 64'(n_overlap), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
